// File: rtl/pipe_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipe_cla_addsub
//
// Pipelined carry-lookahead adder/subtractor. The operands are split into
// SEGMENTS = WIDTH/SEG_W segments. Pipeline stage k resolves segment k using
// 4-bit CLA groups and a group-level lookahead unit, then hands its carry to
// stage k+1. The last stage register is the output register, so the result
// appears SEGMENTS enabled edges after acceptance (acceptance edge included).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (== global pipeline enable)
//   add_1      operand A
//   add_2      operand B
//   c_in       carry-in, used only when sub = 0
//   sub        0: A + B + c_in, 1: A - B (A + ~B + 1)
//   in_sat     signed-saturation request (CLA_SATURATE_EN builds only)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result
//   c_out      carry out of the MSB ("no borrow" when subtracting)
//   ovf        two's-complement signed overflow
//
// Build option:
//   CLA_SATURATE_EN  when defined, a beat with in_sat = 1 that overflows has
//                    its sum clamped to the signed extreme in the final stage.
//                    When undefined, in_sat is ignored and the sum wraps.
//
// WIDTH must be a multiple of SEG_W, and SEG_W a multiple of 4.
// -----------------------------------------------------------------------------
module pipe_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SEGMENTS = WIDTH / SEG_W;
  localparam int NGRP     = SEG_W / 4;
  localparam int LAST     = SEGMENTS - 1;

  // Result of resolving one segment: its sum bits, the carry out of the
  // segment and the carry into its top bit (needed for signed overflow).
  typedef struct packed {
    logic [SEG_W-1:0] s;
    logic             cout;
    logic             cmsb;
  } seg_res_t;

  // One segment of carry-lookahead. Every carry is formed as a flat
  // sum-of-products of generate/propagate terms, so there is no ripple
  // between groups or between bits of a group.
  function automatic seg_res_t cla_seg(
    input logic [SEG_W-1:0] a,
    input logic [SEG_W-1:0] b,
    input logic             cin
  );
    logic [SEG_W-1:0] p, g, c;
    logic [NGRP-1:0]  gp, gg;
    logic [NGRP:0]    gc;
    logic             term, cc;
    seg_res_t         r;
    p = a ^ b;
    g = a & b;
    // Group propagate / generate.
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        term = g[4*j+i];
        for (int m = i + 1; m < 4; m++) term = term & p[4*j+m];
        gg[j] = gg[j] | term;
      end
    end
    // Group carries from the segment carry-in.
    for (int j = 0; j <= NGRP; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    // Bit carries inside each group from that group's carry-in.
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < 4; i++) begin
        term = gc[j];
        for (int m = 0; m < i; m++) term = term & p[4*j+m];
        cc = term;
        for (int l = 0; l < i; l++) begin
          term = g[4*j+l];
          for (int m = l + 1; m < i; m++) term = term & p[4*j+m];
          cc = cc | term;
        end
        c[4*j+i] = cc;
      end
    end
    r.s    = p ^ c;
    r.cout = gc[NGRP];
    r.cmsb = c[SEG_W-1];
    return r;
  endfunction

  // Stage registers. Operand bits are carried in full width; bits already
  // consumed by earlier segments are simply not read downstream.
  logic [SEGMENTS-1:0]            st_v, st_c, st_ovf;
  logic [SEGMENTS-1:0][WIDTH-1:0] st_sum, st_a, st_b;
  logic [SEGMENTS-1:0]            nxt_v, nxt_c, nxt_ovf;
  logic [SEGMENTS-1:0][WIDTH-1:0] nxt_sum, nxt_a, nxt_b;
`ifdef CLA_SATURATE_EN
  logic [SEGMENTS-1:0]            st_sat, nxt_sat;
`endif

  // Global stall: the whole pipe advances only when the output slot is
  // empty or being drained this cycle.
  logic en;
  assign en       = !st_v[LAST] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, sum_src, sum_mix;
    logic             cin_src, v_src, ovf_k;
    seg_res_t         seg;
`ifdef CLA_SATURATE_EN
    logic             sat_src;
`endif

    if (k == 0) begin : g_head
      // B is inverted here and the +1 of the subtraction enters as carry-in.
      assign a_src   = add_1;
      assign b_src   = sub ? ~add_2 : add_2;
      assign cin_src = sub | c_in;
      assign sum_src = '0;
      assign v_src   = in_valid;
`ifdef CLA_SATURATE_EN
      assign sat_src = in_sat;
`endif
    end else begin : g_body
      assign a_src   = st_a[k-1];
      assign b_src   = st_b[k-1];
      assign cin_src = st_c[k-1];
      assign sum_src = st_sum[k-1];
      assign v_src   = st_v[k-1];
`ifdef CLA_SATURATE_EN
      assign sat_src = st_sat[k-1];
`endif
    end

    assign seg   = cla_seg(a_src[k*SEG_W +: SEG_W], b_src[k*SEG_W +: SEG_W], cin_src);
    // Only meaningful in the last stage, where the segment top bit is the MSB.
    assign ovf_k = seg.cmsb ^ seg.cout;

    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      sum_mix                    = sum_src;
      sum_mix[k*SEG_W +: SEG_W]  = seg.s;
`ifdef CLA_SATURATE_EN
      // On overflow both effective operand MSBs agree, so A's MSB gives
      // the direction of the clamp.
      if (k == LAST && sat_src && ovf_k) begin
        sum_mix = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end

    assign nxt_sum[k] = sum_mix;
    assign nxt_a[k]   = a_src;
    assign nxt_b[k]   = b_src;
    assign nxt_c[k]   = seg.cout;
    assign nxt_v[k]   = v_src;
    assign nxt_ovf[k] = ovf_k;
`ifdef CLA_SATURATE_EN
    assign nxt_sat[k] = sat_src;
`endif
  end

  // NOTE: the pipeline data registers are reset along with the valid bits;
  // they are few, and it makes sum/c_out/ovf read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v   <= '0;
      st_c   <= '0;
      st_ovf <= '0;
      st_sum <= '0;
      st_a   <= '0;
      st_b   <= '0;
`ifdef CLA_SATURATE_EN
      st_sat <= '0;
`endif
    end else if (en) begin
      // NOTE: non-blocking assignments so every stage samples the previous
      // stage's value from before this edge.
      st_v   <= nxt_v;
      st_c   <= nxt_c;
      st_ovf <= nxt_ovf;
      st_sum <= nxt_sum;
      st_a   <= nxt_a;
      st_b   <= nxt_b;
`ifdef CLA_SATURATE_EN
      st_sat <= nxt_sat;
`endif
    end
  end

  assign out_valid = st_v[LAST];
  assign sum       = st_sum[LAST];
  assign c_out     = st_c[LAST];
  assign ovf       = st_ovf[LAST];

  // Consumed operand bits, the last stage's operand copy, intermediate
  // overflow flags and (without saturation) in_sat have no reader.
  logic unused_bits;
`ifdef CLA_SATURATE_EN
  assign unused_bits = ^{st_a, st_b, st_ovf, st_sat};
`else
  assign unused_bits = ^{st_a, st_b, st_ovf, in_sat};
`endif

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_addsub
//
// Self-checking bench for pipe_cla_addsub at WIDTH=16, SEG_W=4 (4 stages).
// Expected results are pushed to a scoreboard queue when a beat is offered
// and popped by a monitor when the DUT retires a result. Inputs change #1
// after a rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_cla_addsub;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = W / SW;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } exp_t;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] add_1, add_2;
  logic         c_in, sub, in_sat;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         c_out, ovf;

  int   errors  = 0;
  int   checks  = 0;
  int   retired = 0;
  exp_t sb[$];
  exp_t mon_e;

  pipe_cla_addsub #(.WIDTH(W), .SEG_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .add_1    (add_1),
    .add_2    (add_2),
    .c_in     (c_in),
    .sub      (sub),
    .in_sat   (in_sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic, written directly from the add/sub definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s, input logic sat);
    logic [W-1:0] be;
    logic [W:0]   full;
    exp_t         e;
    be     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    e.ovf   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
`ifdef CLA_SATURATE_EN
    if (sat && e.ovf) e.sum = a[W-1] ? 16'h8000 : 16'h7FFF;
`else
    if (sat) e.sum = e.sum;
`endif
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.c_out = c; e.ovf = o;
    return e;
  endfunction

  // Scoreboard monitor: a result retires on the next edge when out_valid &&
  // out_ready are seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      retired++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got sum=%h c_out=%b ovf=%b, scoreboard empty",
                 sum, c_out, ovf);
      end else begin
        mon_e = sb.pop_front();
        if ({sum, c_out, ovf} !== {mon_e.sum, mon_e.c_out, mon_e.ovf}) begin
          errors++;
          $display("FAIL result: got sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
                   sum, c_out, ovf, mon_e.sum, mon_e.c_out, mon_e.ovf);
        end
      end
    end
  end

  // Offer one beat (called at posedge+1), wait for acceptance, return at
  // posedge+1 after the accept edge with in_valid dropped.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic s, input logic sat, input exp_t e);
    int n;
    add_1 = a; add_2 = b; c_in = ci; sub = s; in_sat = sat; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count enabled edges from acceptance until out_valid; pipe must be empty.
  task automatic send_measure(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ci, input logic s, input logic sat, input exp_t e);
    int n;
    send(a, b, ci, s, sat, e);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks++;
    if (!out_valid || n != LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (out_valid=%b), want %0d", name, n, out_valid, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, want 0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    add_1 = '0; add_2 = '0; c_in = 1'b0; sub = 1'b0; in_sat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    checks++; if (sum !== '0)         begin errors++; $display("FAIL reset_sum: got %h, want 0000", sum); end
    checks++; if (c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out: got %b, want 0", c_out); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    send_measure("add_cin1", 16'd432, 16'd765, 1'b1, 1'b0, 1'b0, mk(16'd1198, 1'b0, 1'b0));
    send_measure("add_cin0", 16'd432, 16'd765, 1'b0, 1'b0, 1'b0, mk(16'd1197, 1'b0, 1'b0));
    wait_drain("basic");
  endtask

  task automatic test_carry_chain();
    send(16'd65534, 16'd1, 1'b1, 1'b0, 1'b0, mk(16'd0, 1'b1, 1'b0));
    send(16'd65534, 16'd1, 1'b0, 1'b0, 1'b0, mk(16'd65535, 1'b0, 1'b0));
    send(16'hFFFF, 16'd1, 1'b0, 1'b0, 1'b0, mk(16'd0, 1'b1, 1'b0));
    wait_drain("carry");
  endtask

  task automatic test_sub_ovf();
    send(16'd5, 16'd7, 1'b1, 1'b1, 1'b0, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'd7, 16'd5, 1'b0, 1'b1, 1'b0, mk(16'h0002, 1'b1, 1'b0));
    send(16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
`ifdef CLA_SATURATE_EN
    send(16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b1, mk(16'h7FFF, 1'b0, 1'b1));
    send(16'h8000, 16'd1, 1'b0, 1'b1, 1'b1, mk(16'h8000, 1'b1, 1'b1));
`else
    send(16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
    send(16'h8000, 16'd1, 1'b0, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
`endif
    wait_drain("sub_ovf");
  endtask

  task automatic test_back_to_back_stall();
    int           base;
    logic [W-1:0] held;
    base = retired;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'(i), W'(100 * i), 1'b0, 1'b0, 1'b0, mk(W'(101 * i), 1'b0, 1'b0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = sum;
        for (int s = 0; s < 3; s++) begin
          if (s != 0) @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== held) begin
            errors++;
            $display("FAIL stall_hold: got in_ready=%b out_valid=%b sum=%h, want 0 1 %h",
                     in_ready, out_valid, sum, held);
          end
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("stream");
    checks++;
    if (retired - base != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d results, want 8", retired - base);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    send(16'd10, 16'd20, 1'b0, 1'b0, 1'b0, mk(16'd30, 1'b0, 1'b0));
    send(16'd11, 16'd21, 1'b0, 1'b0, 1'b0, mk(16'd32, 1'b0, 1'b0));
    send(16'd12, 16'd22, 1'b0, 1'b0, 1'b0, mk(16'd34, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got out_valid=%b sum=%h in_ready=%b, want 0 0000 1",
               out_valid, sum, in_ready);
    end
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_measure("post_reset", 16'd1, 16'd2, 1'b0, 1'b0, 1'b0, mk(16'd3, 1'b0, 1'b0));
    wait_drain("midreset");
  endtask

  task automatic test_bubbles();
    logic [7:0]  pat;
    logic [15:0] ov;
    logic        want;
    pat = 8'b0101_0101;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        add_1 = W'(c + 1); add_2 = 16'd3; c_in = 1'b0; sub = 1'b0; in_sat = 1'b0;
        in_valid = pat[c];
        if (pat[c]) sb.push_back(model(W'(c + 1), 16'd3, 1'b0, 1'b0, 1'b0));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      ov[c] = out_valid;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 16; c++) begin
      want = (c >= LAT && c - LAT < 8) ? pat[c-LAT] : 1'b0;
      checks++;
      if (ov[c] !== want) begin
        errors++;
        $display("FAIL bubble_pattern[%0d]: got out_valid=%b, want %b", c, ov[c], want);
      end
    end
    wait_drain("bubbles");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         ci, s, sat;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          a = W'($urandom); b = W'($urandom);
          ci = 1'($urandom); s = 1'($urandom); sat = 1'($urandom);
          if (i == 0) begin a = 16'h7FFF; b = 16'h7FFF; s = 1'b0; sat = 1'b1; end
          send(a, b, ci, s, sat, model(a, b, ci, s, sat));
        end
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_sub_ovf();
    test_back_to_back_stall();
    test_mid_reset();
    test_bubbles();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_cla_addsub.md
Name: pipe_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 16-bit hierarchical CLA.
- The operand is split into segments. Each pipeline stage resolves one segment with 4-bit CLA groups and group-level lookahead, then passes its carry to the next stage.
- Used as the wide accumulate/add primitive in the FIR datapath. Valid/ready handshake with backpressure; throughput of one operation per clock.

Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of SEG_W.
- SEG_W, 8: segment width resolved per pipeline stage. Must be a multiple of 4.
- SEGMENTS, WIDTH/SEG_W: derived, not overridable. Equals the pipeline depth.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- add_1  in  WIDTH  operand A.
- add_2  in  WIDTH  operand B.
- c_in  in  1  carry-in. Used only when sub=0.
- sub  in  1  0: A+B+c_in; 1: A-B.
- in_sat  in  1  request signed saturation. Used only with CLA_SATURATE_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. For sub=1 it means "no borrow" (A>=B unsigned).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - sub=0: {c_out,sum} = A + B + c_in.
  - sub=1: {c_out,sum} = A + ~B + 1; c_in is ignored.
  - ovf = carry into MSB XOR carry out of MSB.
  - The B inversion is applied in stage 0.
- Segment structure:
  - Segment k covers bits [k*SEG_W +: SEG_W].
  - Within a segment: 4-bit groups produce group P/G; a lookahead unit forms group carries from the segment carry-in; then sum bits are formed.
  - No ripple across groups inside a segment.
- Pipeline:
  - Stage k holds: sum bits for segments 0..k, the carry out of segment k, the unprocessed upper operand bits, sub, in_sat and a valid bit.
  - On the acceptance edge, stage 0 captures segment 0. Each later enabled edge advances one stage.
  - Latency: the result is presented on out_valid after SEGMENTS enabled edges, counting the acceptance edge. With SEGMENTS=1, out_valid is high immediately after the accept edge.
- Handshake:
  - Beat accepted on a rising edge when in_valid && in_ready.
  - Result retired on a rising edge when out_valid && out_ready.
  - Global stall: enable = !out_valid || out_ready; in_ready = enable.
  - The combinational out_ready -> in_ready path is permitted.
  - When enable=0, every stage register, sum, c_out and ovf hold.
  - Bubbles (in_valid=0 while enabled) propagate as valid=0. Stage data may change under valid=0; the checker must ignore it.
  - Back-to-back beats with out_ready held high give one result per cycle, in order.
- Outputs (sum, c_out, ovf, out_valid) are registered. No combinational path from operand inputs to outputs.
- Reset (rst_n low, asynchronous):
  - All valid bits, out_valid, sum, c_out and ovf go to 0.
  - in_ready reads 1 while out_valid=0.
  - In-flight beats are discarded, including under mid-operation reset.
  - The first accept is possible on the first rising edge after rst_n deasserts.
- Boundaries:
  - All-ones + 1: sum wraps to 0 with c_out=1.
  - Full pipeline plus stall: no beat is lost or duplicated.
  - in_valid is ignored while in_ready=0.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined:
  - If in_sat=1 and ovf=1, sum clamps: to {0,{WIDTH-1{1}}} when the MSBs of the effective operands are 0, otherwise to {1,{WIDTH-1{0}}}.
  - ovf still reports 1. c_out is unchanged.
  - Clamp is applied in the final stage; latency unchanged.
- Undefined: in_sat is ignored, sum always wraps, and no clamp logic is synthesised.

Test Plan (WIDTH=16, SEG_W=4, out_ready=1 unless stated):
- Basic add: A=432, B=765, c_in=1, sub=0 -> sum=1198, c_out=0, ovf=0, 4 edges after accept. Same operands with c_in=0 -> sum=1197.
- Carry chain: A=65534, B=1, c_in=1 -> sum=0, c_out=1, ovf=0. With c_in=0 -> sum=65535, c_out=0.
- Subtract and overflow: sub=1, A=5, B=7 -> sum=0xFFFE, c_out=0, ovf=0. sub=0, A=0x7FFF, B=1 -> sum=0x8000, ovf=1. With CLA_SATURATE_EN and in_sat=1 -> sum=0x7FFF, ovf=1.
- Streaming with backpressure: 8 consecutive beats (A=i, B=100*i); hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs hold, all 8 results (101*i) delivered in order, none dropped.
- Mid-operation reset: 3 beats in flight, pulse rst_n low asynchronously between edges -> out_valid=0, sum=0 immediately. After release, the next beat (A=1, B=2) returns 3 with correct latency.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates with the same pattern, delayed by the pipeline latency.
